// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues in-order imem requests and buffers words for decode.
// Optional IFU_BYPASS_EN: forwards a response straight to decode when the prefetch FIFO is empty.
module inst_fetch_unit #(
    parameter int unsigned           ADDR_W   = 32,
    parameter int unsigned           DATA_W   = 32,
    parameter int unsigned           DEPTH    = 4,
    parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc, rsp_pc;
    logic [CNT_W-1:0]  outstanding, drop, wr_ptr, rd_ptr, occupancy, drop_redir;
    logic [CNT_W:0]    credit_used;
    logic [PTR_W-1:0]  wr_idx, rd_idx;
    entry_t            mem [DEPTH];
    logic              empty, grant, keep, push, pop;

    assign occupancy   = wr_ptr - rd_ptr;
    assign empty       = (occupancy == '0);
    assign wr_idx      = wr_ptr[PTR_W-1:0];
    assign rd_idx      = rd_ptr[PTR_W-1:0];
    assign credit_used = {1'b0, occupancy} + {1'b0, outstanding};
    // a response landing in the redirect cycle is already retired from the drop count
    assign drop_redir  = outstanding - CNT_W'(imem_rvalid);

    assign imem_req  = (state != BOOT) && !redirect && (credit_used < (CNT_W+1)'(DEPTH));
    assign imem_addr = pc;
    assign grant     = imem_req && imem_gnt;
    assign keep      = imem_rvalid && (drop == '0) && !redirect;
    assign pop       = !empty && inst_ready && !redirect;

`ifdef IFU_BYPASS_EN
    logic bypass;
    assign bypass     = keep && empty;
    assign push       = keep && !(bypass && inst_ready);
    assign inst_valid = !empty || bypass;
    assign inst       = bypass ? imem_rdata : mem[rd_idx].data;
    assign inst_pc    = bypass ? rsp_pc     : mem[rd_idx].pc;
`else
    assign push       = keep;
    assign inst_valid = !empty;
    assign inst       = mem[rd_idx].data;
    assign inst_pc    = mem[rd_idx].pc;
`endif

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state: redirects re-evaluate drain need, DRAIN exits when the last stale word lands
    always_comb begin
        state_nxt = state;
        case (state)
            BOOT: state_nxt = RUN;
            RUN, DRAIN: begin
                if (redirect) begin
                    state_nxt = (drop_redir != '0) ? DRAIN : RUN;
                end else if ((state == DRAIN) && imem_rvalid && (drop == CNT_W'(1))) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = BOOT;
        endcase
    end

    // fetch PC, credit counters and prefetch FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (redirect) begin
            pc          <= redirect_pc;
            rsp_pc      <= redirect_pc;
            outstanding <= drop_redir;
            drop        <= drop_redir;
            rd_ptr      <= wr_ptr;
        end else begin
            if (grant) begin
                pc <= pc + ADDR_W'(1);
            end
            if (grant && !imem_rvalid) begin
                outstanding <= outstanding + CNT_W'(1);
            end else if (!grant && imem_rvalid) begin
                outstanding <= outstanding - CNT_W'(1);
            end
            if (imem_rvalid && (drop != '0)) begin
                drop <= drop - CNT_W'(1);
            end
            if (keep) begin
                rsp_pc <= rsp_pc + ADDR_W'(1);
            end
            if (push) begin
                mem[wr_idx] <= '{data: imem_rdata, pc: rsp_pc};
                wr_ptr      <= wr_ptr + CNT_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: a behavioural imem answers grants, kept responses are queued as expectations.
module tb_inst_fetch_unit;

    localparam int unsigned DEPTH = 4;
`ifdef IFU_BYPASS_EN
    localparam int EXP_LAT = 2;
`else
    localparam int EXP_LAT = 3;
`endif

    logic        clk, rst_n;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid, inst_ready;
    logic [31:0] inst, inst_pc;

    inst_fetch_unit #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; bit stale; } pend_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;

    pend_t pend[$];
    ent_t  exp_q[$];

    int          n_tests = 0, n_fail = 0;
    int          cyc = 0, pops = 0, lat = 1;
    logic [31:0] mpc = 32'h0, last_pc = 32'h0, redir_pc_v = 32'h0, s_addr;
    bit          gnt_en = 0, resp_en = 1, ready_v = 0, redir_v = 0;
    logic        s_req, s_valid;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0F1E_2D3C;
    endfunction

    // one clock: drive at posedge+1, sample/score at negedge, return aligned to next posedge+1
    task automatic step();
        pend_t head;
        ent_t  e;
        bit    deliver;
        inst_ready  = ready_v;
        redirect    = redir_v;
        redirect_pc = redir_pc_v;
        imem_gnt    = gnt_en;
        deliver     = resp_en && (pend.size() > 0);
        if (deliver) deliver = (pend[0].due <= cyc);
        imem_rvalid = deliver;
        imem_rdata  = 32'hDEAD_BEEF;
        if (deliver) imem_rdata = mem_word(pend[0].addr);
        #4;
        s_req = imem_req; s_valid = inst_valid; s_addr = imem_addr;
        if (redir_v) begin
            n_tests++;
            if (imem_req !== 1'b0) begin
                n_fail++; $display("FAIL redirect_withdraw: imem_req=%b required 0", imem_req);
            end
        end
        if (deliver) begin
            head = pend.pop_front();
            if (!head.stale && !redir_v) exp_q.push_back('{head.addr, mem_word(head.addr)});
        end
        if (inst_valid === 1'b1 && ready_v && !redir_v) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++; $display("FAIL unexpected_inst: pc=%h data=%h with nothing expected", inst_pc, inst);
            end else begin
                e = exp_q.pop_front();
                if (inst_pc !== e.pc || inst !== e.data) begin
                    n_fail++;
                    $display("FAIL inst_order: got pc=%h data=%h required pc=%h data=%h", inst_pc, inst, e.pc, e.data);
                end
            end
            pops++; last_pc = inst_pc;
        end
        if (imem_req === 1'b1 && gnt_en && !redir_v) begin
            n_tests++;
            if (imem_addr !== mpc) begin
                n_fail++; $display("FAIL fetch_addr: imem_addr=%h required %h", imem_addr, mpc);
            end
            pend.push_back('{mpc, cyc + lat, 1'b0});
            mpc = mpc + 32'd1;
        end
        if (redir_v) begin
            for (int i = 0; i < pend.size(); i++) pend[i].stale = 1'b1;
            exp_q.delete();
            mpc = redir_pc_v;
        end
        n_tests++;
        if (exp_q.size() + pend.size() > DEPTH) begin
            n_fail++; $display("FAIL credit: occupancy+outstanding=%0d exceeds %0d", exp_q.size() + pend.size(), DEPTH);
        end
        @(posedge clk); #1;
        cyc++;
        redir_v = 1'b0;
    endtask

    task automatic wait_pops(input int target, input int budget, input string name);
        int n = 0;
        while (pops < target && n < budget) begin step(); n++; end
        n_tests++;
        if (pops < target) begin
            n_fail++; $display("FAIL %s_timeout: pops=%0d required %0d", name, pops, target);
        end
    endtask

    task automatic check_cleared(input string name);
        n_tests++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL %s: req=%b valid=%b inst=%h pc=%h required all 0", name, imem_req, inst_valid, inst, inst_pc);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
        redirect = 0; redirect_pc = '0; inst_ready = 0;
        #2;
        check_cleared("reset_outputs");
        @(posedge clk); #1;
        rst_n = 1'b1;
        gnt_en = 1; ready_v = 1; resp_en = 1; lat = 1; mpc = 32'h0;
        step();
        n_tests++;
        if (s_req !== 1'b0) begin
            n_fail++; $display("FAIL boot_no_req: imem_req=%b required 0", s_req);
        end
    endtask

    task automatic test_stream();
        int n = 0, gaps = 0, p0;
        while (n < 10) begin
            step(); n++;
            if (s_valid === 1'b1) break;
        end
        n_tests++;
        if (n != EXP_LAT) begin
            n_fail++; $display("FAIL first_latency: first valid after %0d cycles required %0d", n, EXP_LAT);
        end
        p0 = pops;
        for (int i = 0; i < 16; i++) begin
            step();
            if (s_valid !== 1'b1) gaps++;
        end
        n_tests++;
        if (gaps != 0 || pops - p0 != 16) begin
            n_fail++; $display("FAIL stream_gaps: gaps=%0d pops=%0d required 0 and 16", gaps, pops - p0);
        end
    endtask

    task automatic test_backpressure();
        int p0;
        ready_v = 0;
        repeat (12) step();
        n_tests++;
        if (s_req !== 1'b0 || s_valid !== 1'b1) begin
            n_fail++; $display("FAIL credits_exhausted: req=%b valid=%b required 0 1", s_req, s_valid);
        end
        ready_v = 1; gnt_en = 0; p0 = pops;
        repeat (8) step();
        n_tests++;
        if (pops - p0 != int'(DEPTH) || inst_valid !== 1'b0) begin
            n_fail++; $display("FAIL drain_count: drained=%0d valid=%b required %0d 0", pops - p0, inst_valid, DEPTH);
        end
    endtask

    task automatic test_gnt_stall();
        gnt_en = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_tests++;
            if (s_req !== 1'b1 || s_addr !== mpc) begin
                n_fail++; $display("FAIL stall_hold: req=%b addr=%h required 1 %h", s_req, s_addr, mpc);
            end
        end
        gnt_en = 1;
        repeat (4) step();
    endtask

    task automatic test_redirect_drain();
        int p0;
        gnt_en = 0;
        repeat (6) step();
        resp_en = 0; gnt_en = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if (s_req !== 1'b1) begin
                n_fail++; $display("FAIL drain_setup_req: req=%b required 1 at grant %0d", s_req, i);
            end
        end
        redir_v = 1; redir_pc_v = 32'h40;
        step();
        resp_en = 1; p0 = pops;
        wait_pops(p0 + 1, 20, "redirect_drain");
        n_tests++;
        if (last_pc !== 32'h40) begin
            n_fail++; $display("FAIL redirect_target: inst_pc=%h required 00000040", last_pc);
        end
        repeat (6) step();
    endtask

    task automatic test_redirect_collide();
        int p0;
        repeat (4) step();
        redir_v = 1; redir_pc_v = 32'h80;
        step();
        n_tests++;
        if (s_valid !== 1'b1 || inst_valid !== 1'b0) begin
            n_fail++; $display("FAIL collide_flush: valid_at=%b valid_after=%b required 1 0", s_valid, inst_valid);
        end
        p0 = pops;
        wait_pops(p0 + 1, 20, "collide");
        n_tests++;
        if (last_pc !== 32'h80) begin
            n_fail++; $display("FAIL collide_target: inst_pc=%h required 00000080", last_pc);
        end
        repeat (4) step();
    endtask

    task automatic test_mid_reset();
        int p0;
        #2;
        rst_n = 1'b0;
        #1;
        check_cleared("mid_reset_outputs");
        pend.delete(); exp_q.delete(); mpc = 32'h0;
        imem_rvalid = 0; imem_gnt = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();
        n_tests++;
        if (s_req !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_boot: imem_req=%b required 0", s_req);
        end
        p0 = pops;
        wait_pops(p0 + 1, 20, "mid_reset");
        n_tests++;
        if (last_pc !== 32'h0) begin
            n_fail++; $display("FAIL mid_reset_restart: inst_pc=%h required 00000000", last_pc);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_gnt_stall();
        test_redirect_drain();
        test_redirect_collide();
        lat = 2;
        repeat (8) step();
        lat = 1;
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction fetch front end that sits directly upstream of the decode / control-unit stage.
- Owns the fetch PC, which increments by 1 because instruction memory is word-addressed.
- Issues in-order requests to instruction memory and buffers the returned words with their PCs in a small prefetch FIFO.
- Presents instructions to decode over a valid/ready handshake; branch and jump redirects flush the FIFO and discard stale in-flight responses.

Parameters:
- ADDR_W, 32, width of PC and memory address.
- DATA_W, 32, instruction width.
- DEPTH, 4, prefetch FIFO entries; must be a power of 2, minimum 2.
- RESET_PC, 0, fetch PC value loaded at reset.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Rst  in  1  asynchronous, active-low reset.
- Imem_Req  out  1  fetch request valid.
- Imem_Addr  out  ADDR_W  fetch address; equals the current fetch PC.
- Imem_Gnt  in  1  request accepted this cycle when high together with Imem_Req.
- Imem_Rvalid  in  1  response valid; responses return in request order, latency of 1 or more cycles.
- Imem_Rdata  in  DATA_W  response instruction word.
- Redirect  in  1  branch/jump taken; single-cycle pulse.
- Redirect_Pc  in  ADDR_W  new fetch target.
- Inst_Valid  out  1  instruction available to decode.
- Inst  out  DATA_W  instruction at the FIFO head.
- Inst_Pc  out  ADDR_W  PC of Inst.
- Inst_Ready  in  1  decode accepts Inst this cycle.

Behaviour:
- Reset (Rst=0, asynchronous):
  - fetch PC = RESET_PC; FIFO empty; outstanding = 0; drop = 0; state = BOOT.
  - Imem_Req=0, Inst_Valid=0, Inst=0, Inst_Pc=0.
- FSM:
  - BOOT: one cycle after reset release with Imem_Req=0, then go to RUN.
  - RUN: normal fetch.
  - DRAIN: drop>0, entered on a Redirect that has outstanding requests; return to RUN the cycle drop reaches 0.
  - A Redirect in any non-BOOT state re-evaluates DRAIN/RUN.
- Counter widths: outstanding and drop are clog2(DEPTH)+1 bits. FIFO occupancy is also clog2(DEPTH)+1 bits, with wrap-around read/write pointers.
- Credit rule: Imem_Req=1 only when state is RUN or DRAIN, Redirect=0, and occupancy + outstanding < DEPTH. This guarantees the FIFO never overflows.
- Request acceptance:
  - On Imem_Req & Imem_Gnt: fetch PC += 1 (mod 2^ADDR_W) and outstanding += 1.
  - Without Gnt, Imem_Req and Imem_Addr hold stable. The only exception is a Redirect, which withdraws the request that cycle.
- Response handling (Imem_Rvalid=1): outstanding -= 1.
  - If drop>0: discard the word and decrement drop.
  - Otherwise: push {Rdata, PC tag} into the FIFO. The tag comes from a response-PC register that increments per accepted response and is reloaded on Redirect.
- Simultaneous grant and response: outstanding is unchanged.
- Output side: Inst_Valid = FIFO not empty; Inst and Inst_Pc come from the head entry. Inst_Valid & Inst_Ready pops the head.
  - Push and pop in the same cycle: occupancy is unchanged.
  - Pop while the FIFO is empty cannot occur.
- Redirect, in the same cycle it is asserted:
  - FIFO flushed, fetch PC = Redirect_Pc, response-PC = Redirect_Pc.
  - drop = outstanding minus any response accepted in that same cycle; that response is also discarded.
  - Inst_Valid goes low the next cycle.
  - Redirect takes priority over any pop, push or grant in that cycle.
- Latency: first Inst_Valid arrives one cycle after the Imem_Rvalid carrying that word, through the FIFO registers.
- Reset mid-operation: all state clears immediately. Responses to pre-reset requests arriving after reset are the memory's responsibility; the memory is reset on the same Rst.

Optional Feature:
- IFU_BYPASS_EN
- Defined:
  - When the FIFO is empty, drop=0, Redirect=0 and Imem_Rvalid=1, Imem_Rdata and its PC drive Inst/Inst_Pc combinationally and Inst_Valid=1 in the same cycle.
  - If Inst_Ready=1, the word is consumed without a push; otherwise it is pushed normally.
  - Latency becomes 0 cycles.
- Undefined: no combinational path from Imem_* to Inst_*; latency is 1 cycle as above.

Test Plan:
- Reset then release, Gnt=1, Rvalid one cycle after each grant, Inst_Ready=1 -> Imem_Addr sequence 0,1,2,3…; Inst_Pc 0,1,2… in order; no gaps after the first instruction.
- Inst_Ready=0, Gnt=1, Rvalid=1 -> occupancy + outstanding never exceeds 4; Imem_Req drops once credits are exhausted; releasing Ready drains the words in order.
- 3 requests outstanding, Redirect with Redirect_Pc=0x40 -> the 3 stale responses are dropped; next Inst_Pc=0x40 with its Rdata; state passes through DRAIN back to RUN.
- Redirect in the same cycle as Inst_Valid&Inst_Ready and Imem_Rvalid -> the pop and push are ignored, FIFO empty next cycle, drop accounts for the concurrent response.
- Gnt held low for 5 cycles -> Imem_Req and Imem_Addr stable throughout; fetch PC does not advance.
- Rst asserted mid-stream, asynchronously between clock edges -> outputs clear immediately; after release one BOOT cycle, then fetch restarts at RESET_PC.
